mmio_interconnect: RTL and testbench
====================================

Name: mmio_interconnect

Overview:
- Parametrised memory-mapped interconnect between the cpu data port and N peripheral slaves (progmem, LED, UART data/ctrl/status, ...).
- Decodes the region field of the address and gates the read/write strobes to the selected slave.
- Routes read data back through a registered select pipeline sized to the slave read latency.
- Logs accesses to unmapped regions in sticky error registers and raises an interrupt on them.

Parameters:
N_SLAVES, 5, number of slaves; slave i owns region value i; legal range 1..16
SEL_MSB, 31, upper bit of the region field in addr
SEL_LSB, 28, lower bit of the region field; SEL_MSB-SEL_LSB+1 = RW, with 2^RW >= N_SLAVES
READ_LATENCY, 1, cycles from rstrb to valid s_rdata; legal range 1..4
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
addr  in  32  cpu address
wdata  in  32  cpu write data
wstrb  in  4  cpu byte write strobes
rstrb  in  1  cpu read strobe
rdata  out  32  read data routed to cpu
rvalid  out  1  rdata valid, READ_LATENCY cycles after rstrb
s_addr  out  32  address broadcast to all slaves
s_wdata  out  32  write data broadcast to all slaves
s_rstrb  out  N_SLAVES  per-slave read strobe
s_wstrb  out  4*N_SLAVES  per-slave byte strobes; slave i uses bits [4i+3:4i]
s_rdata  in  32*N_SLAVES  per-slave read data; slave i drives [32i+31:32i]
err_clr  in  1  clears the error registers
err_valid  out  1  sticky: an unmapped access has occurred
err_addr  out  32  address of the most recent unmapped access
err_write  out  1  1 if the most recent unmapped access was a write
err_count  out  ERR_CNT_W  count of unmapped accesses, saturating
irq  out  1  equals err_valid

Behaviour:
- Reset applies on a clk edge with rst=0. All registered outputs go to 0: rvalid, err_*, irq, and the select pipeline (held as "none").
- Decode (combinational):
  - sel = addr[SEL_MSB:SEL_LSB].
  - mapped = (sel < N_SLAVES).
  - s_addr = addr; s_wdata = wdata.
  - s_rstrb[i] = rstrb & mapped & (sel==i).
  - s_wstrb slice i = wstrb & {4{mapped & (sel==i)}}.
  - Unmapped accesses drive no slave strobe.
- Read routing pipeline:
  - Stage 0 captures {req=rstrb, mapped, sel} every cycle; stages 1..READ_LATENCY-1 shift.
  - Final stage: rvalid = req; rdata = (req & mapped) ? s_rdata slice[sel] : 32'h0.
  - When not rvalid, rdata = 32'h0.
  - Back-to-back reads to different slaves every cycle are supported. Each response uses the sel latched at its own request, not the current addr.
- Error logging: an access is an event when (rstrb | (wstrb != 0)) & !mapped.
  - On an event: err_valid <= 1, err_addr <= addr, err_write <= (wstrb != 0), err_count <= err_count+1, saturating at all-ones.
  - rstrb together with a nonzero wstrb in the same cycle counts as one event, with err_write=1.
  - An unmapped read still produces rvalid=1 with rdata=0 after READ_LATENCY cycles.
- err_clr without an event: clears err_valid, err_addr, err_write and err_count to 0 on the next edge.
- err_clr together with an event: the clear applies first, then the event. Result: err_valid=1, err_count=1, err_addr = the new address.
- Reset during an in-flight read: the pipeline is flushed and no rvalid is produced afterwards.
- Writes have no response and no latency; the slave samples its strobe in the same cycle.

Decomposition:
- Package mmio_pkg holds:
  - region field constants (SEL_MSB/SEL_LSB defaults);
  - the slave index constants SLV_MEM=0, SLV_LED=1, SLV_UART_DATA=2, SLV_UART_CTRL=3, SLV_UART_STATUS=4;
  - the select-stage struct {req, mapped, sel}.
- One sub-module, mmio_rd_pipe: a READ_LATENCY-deep shift register of select-stage entries with synchronous active-low clear.
- Decode, strobe gating and error logging stay in mmio_interconnect.

Test Plan:
- Reset with rst=0 for 2 cycles while rstrb=1 and addr=0x0000_0010 -> after release, rvalid=0, err_count=0, irq=0.
- Read 0x0000_0010 then 0x4000_0000 on consecutive cycles, with slave0=0xAAAA_0001 and slave4=0x0000_0200 -> rvalid high for 2 cycles; rdata = 0xAAAA_0001 then 0x0000_0200. Repeat with READ_LATENCY=3.
- Write 0x1000_0000, wstrb=4'b0011 -> only s_wstrb[7:4]=4'b0011 is asserted; all other slices are 0 and s_rstrb=0.
- Write 0x7000_0004, wstrb=4'hF -> no slave strobe; next cycle err_valid=1, err_addr=0x7000_0004, err_write=1, err_count=1, irq=1.
- 300 unmapped reads at 0xF000_0000 -> err_count=255 (saturated); each read gives rvalid=1 with rdata=0 and err_write=0.
- err_clr=1 in the same cycle as an unmapped read of 0x9000_0000 -> err_count=1, err_addr=0x9000_0000. Then err_clr alone -> all err_* fields=0 and irq=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and the read-select stage type for the MMIO interconnect.
package mmio_pkg;

  localparam int SEL_MSB_DEF = 31;
  localparam int SEL_LSB_DEF = 28;
  localparam int SEL_IDX_W   = 4;   // enough to name any of up to 16 slaves

  localparam int SLV_MEM         = 0;
  localparam int SLV_LED         = 1;
  localparam int SLV_UART_DATA   = 2;
  localparam int SLV_UART_CTRL   = 3;
  localparam int SLV_UART_STATUS = 4;

  typedef struct packed {
    logic                 req;
    logic                 mapped;
    logic [SEL_IDX_W-1:0] sel;
  } sel_stage_t;

endpackage

// File: rtl/mmio_rd_pipe.sv
// Delays the read select so each response is steered by the slave chosen at request time.
module mmio_rd_pipe
  import mmio_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  sel_stage_t d,
  output sel_stage_t q
);

  sel_stage_t stg [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/mmio_interconnect.sv
// CPU-to-peripheral address decode, strobe gating, read-data return and unmapped-access logging.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int N_SLAVES     = SLV_UART_STATUS + 1,
  parameter int SEL_MSB      = SEL_MSB_DEF,
  parameter int SEL_LSB      = SEL_LSB_DEF,
  parameter int READ_LATENCY = 1,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    rstrb,
  output logic [31:0]             rdata,
  output logic                    rvalid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [N_SLAVES-1:0]     s_rstrb,
  output logic [4*N_SLAVES-1:0]   s_wstrb,
  input  logic [32*N_SLAVES-1:0]  s_rdata,
  input  logic                    err_clr,
  output logic                    err_valid,
  output logic [31:0]             err_addr,
  output logic                    err_write,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic                    irq
);

  localparam int RW = SEL_MSB - SEL_LSB + 1;

  logic [RW-1:0] sel;
  logic          mapped;
  logic          wr_any;
  logic          evt;

  assign sel     = addr[SEL_MSB:SEL_LSB];
  assign mapped  = (32'(sel) < 32'(N_SLAVES));
  assign wr_any  = |wstrb;
  assign evt     = (rstrb | wr_any) & ~mapped;
  assign s_addr  = addr;
  assign s_wdata = wdata;

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
    logic hit;
    assign hit                = mapped & (32'(sel) == i);
    assign s_rstrb[i]         = rstrb & hit;
    assign s_wstrb[4*i +: 4]  = wstrb & {4{hit}};
  end

  sel_stage_t st_d, st_q;

  assign st_d.req    = rstrb;
  assign st_d.mapped = mapped;
  assign st_d.sel    = SEL_IDX_W'(sel);  // only meaningful when mapped, which bounds sel below 16

  mmio_rd_pipe #(.DEPTH(READ_LATENCY)) u_rd_pipe (
    .clk (clk),
    .rst (rst),
    .d   (st_d),
    .q   (st_q)
  );

  assign rvalid = st_q.req;

  always_comb begin
    rdata = 32'h0;
    for (int i = 0; i < N_SLAVES; i++)
      if (st_q.req && st_q.mapped && (32'(st_q.sel) == i)) rdata = s_rdata[32*i +: 32];
  end

  // A clear and an event in the same cycle: the event lands on a freshly cleared log.
  logic [ERR_CNT_W-1:0] cnt_base;
  assign cnt_base = err_clr ? '0 : err_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      err_write <= 1'b0;
      err_count <= '0;
    end else if (evt) begin
      err_valid <= 1'b1;
      err_addr  <= addr;
      err_write <= wr_any;
      err_count <= (&cnt_base) ? cnt_base : cnt_base + ERR_CNT_W'(1);
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      err_write <= 1'b0;
      err_count <= '0;
    end
  end

  assign irq = err_valid;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed checks of decode, read return at latency 1 and 3, and error logging.
module tb_mmio_interconnect;

  localparam int NS = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic        rstrb = 1'b0, err_clr = 1'b0;
  logic [32*NS-1:0] s_rdata;

  logic [31:0] rdata1, rdata3, s_addr1, s_addr3, s_wdata1, s_wdata3;
  logic        rvalid1, rvalid3;
  logic [NS-1:0]   s_rstrb1, s_rstrb3;
  logic [4*NS-1:0] s_wstrb1, s_wstrb3;
  logic        err_valid1, err_valid3, err_write1, err_write3, irq1, irq3;
  logic [31:0] err_addr1, err_addr3;
  logic [7:0]  err_count1, err_count3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign s_rdata = {32'h0000_0200, 32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hAAAA_0001};

  mmio_interconnect #(.N_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(28), .READ_LATENCY(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wstrb(wstrb), .rstrb(rstrb),
    .rdata(rdata1), .rvalid(rvalid1), .s_addr(s_addr1), .s_wdata(s_wdata1),
    .s_rstrb(s_rstrb1), .s_wstrb(s_wstrb1), .s_rdata(s_rdata), .err_clr(err_clr),
    .err_valid(err_valid1), .err_addr(err_addr1), .err_write(err_write1),
    .err_count(err_count1), .irq(irq1));

  mmio_interconnect #(.N_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(28), .READ_LATENCY(3), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wstrb(wstrb), .rstrb(rstrb),
    .rdata(rdata3), .rvalid(rvalid3), .s_addr(s_addr3), .s_wdata(s_wdata3),
    .s_rstrb(s_rstrb3), .s_wstrb(s_wstrb3), .s_rdata(s_rdata), .err_clr(err_clr),
    .err_valid(err_valid3), .err_addr(err_addr3), .err_write(err_write3),
    .err_count(err_count3), .irq(irq3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rstrb = 1'b1; addr = 32'h0000_0010;
    step(); step();
    total++;
    if (rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_hold_rvalid got=%b exp=0", rvalid1); end
    rst = 1'b1; rstrb = 1'b0; addr = 32'h0;
    step();
    total++;
    if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin
      bad++; $display("FAIL reset_rvalid got=%b/%b exp=0/0", rvalid1, rvalid3);
    end
    total++;
    if (err_count1 !== 8'h0 || irq1 !== 1'b0 || err_valid1 !== 1'b0) begin
      bad++; $display("FAIL reset_err got cnt=%h irq=%b vld=%b exp 0", err_count1, irq1, err_valid1);
    end
  endtask

  task automatic test_back_to_back();
    logic        ev1 [1:5];
    logic        ev3 [1:5];
    logic [31:0] ed1 [1:5];
    logic [31:0] ed3 [1:5];
    ev1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ed1 = '{32'hAAAA_0001, 32'h0000_0200, 32'h0, 32'h0, 32'h0};
    ev3 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ed3 = '{32'h0, 32'h0, 32'hAAAA_0001, 32'h0000_0200, 32'h0};
    addr = 32'h0000_0010; rstrb = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) addr = 32'h4000_0000;
      if (k == 2) begin addr = 32'h0; rstrb = 1'b0; end
      total++;
      if (rvalid1 !== ev1[k] || rdata1 !== ed1[k]) begin
        bad++; $display("FAIL b2b_lat1 cyc=%0d got v=%b d=%h exp v=%b d=%h", k, rvalid1, rdata1, ev1[k], ed1[k]);
      end
      total++;
      if (rvalid3 !== ev3[k] || rdata3 !== ed3[k]) begin
        bad++; $display("FAIL b2b_lat3 cyc=%0d got v=%b d=%h exp v=%b d=%h", k, rvalid3, rdata3, ev3[k], ed3[k]);
      end
    end
  endtask

  task automatic test_reset_flush();
    addr = 32'h2000_0000; rstrb = 1'b1;
    step();
    rstrb = 1'b0; addr = 32'h0; rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (rvalid3 !== 1'b0 || rvalid1 !== 1'b0) begin
        bad++; $display("FAIL flush cyc=%0d got v=%b/%b exp 0/0", k, rvalid1, rvalid3);
      end
    end
  endtask

  task automatic test_write();
    addr = 32'h1000_0000; wstrb = 4'b0011; wdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if (s_wstrb1 !== 20'h00030 || s_rstrb1 !== 5'b0) begin
      bad++; $display("FAIL write_strb got ws=%h rs=%b exp ws=00030 rs=0", s_wstrb1, s_rstrb1);
    end
    total++;
    if (s_addr1 !== 32'h1000_0000 || s_wdata1 !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL write_bcast got a=%h d=%h exp 10000000/deadbeef", s_addr1, s_wdata1);
    end
    step();
    wstrb = 4'h0;
    total++;
    if (err_valid1 !== 1'b0) begin bad++; $display("FAIL write_noerr got=%b exp=0", err_valid1); end
  endtask

  task automatic test_unmapped_write();
    addr = 32'h7000_0004; wstrb = 4'hF;
    #1;
    total++;
    if (s_wstrb1 !== 20'h0 || s_rstrb1 !== 5'b0) begin
      bad++; $display("FAIL unmapped_strb got ws=%h rs=%b exp 0", s_wstrb1, s_rstrb1);
    end
    step();
    wstrb = 4'h0; addr = 32'h0;
    total++;
    if (err_valid1 !== 1'b1 || err_addr1 !== 32'h7000_0004 || err_write1 !== 1'b1 ||
        err_count1 !== 8'd1 || irq1 !== 1'b1) begin
      bad++; $display("FAIL unmapped_log got v=%b a=%h w=%b c=%0d irq=%b exp 1/70000004/1/1/1",
                      err_valid1, err_addr1, err_write1, err_count1, irq1);
    end
  endtask

  task automatic test_saturate();
    addr = 32'hF000_0000; rstrb = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      total++;
      if (rvalid1 !== 1'b1 || rdata1 !== 32'h0 || err_write1 !== 1'b0) begin
        bad++; $display("FAIL sat_read cyc=%0d got v=%b d=%h w=%b exp 1/0/0", k, rvalid1, rdata1, err_write1);
      end
    end
    rstrb = 1'b0; addr = 32'h0;
    total++;
    if (err_count1 !== 8'd255 || err_addr1 !== 32'hF000_0000) begin
      bad++; $display("FAIL sat_count got c=%0d a=%h exp 255/f0000000", err_count1, err_addr1);
    end
  endtask

  task automatic test_clear();
    addr = 32'h9000_0000; rstrb = 1'b1; err_clr = 1'b1;
    step();
    addr = 32'h0; rstrb = 1'b0; err_clr = 1'b0;
    total++;
    if (err_count1 !== 8'd1 || err_addr1 !== 32'h9000_0000 || err_valid1 !== 1'b1 || err_write1 !== 1'b0) begin
      bad++; $display("FAIL clr_evt got c=%0d a=%h v=%b w=%b exp 1/90000000/1/0",
                      err_count1, err_addr1, err_valid1, err_write1);
    end
    total++;
    if (err_count3 !== 8'd1) begin bad++; $display("FAIL clr_evt_lat3 got c=%0d exp 1", err_count3); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++;
    if (err_valid1 !== 1'b0 || err_addr1 !== 32'h0 || err_write1 !== 1'b0 ||
        err_count1 !== 8'd0 || irq1 !== 1'b0) begin
      bad++; $display("FAIL clr_only got v=%b a=%h w=%b c=%0d irq=%b exp all 0",
                      err_valid1, err_addr1, err_write1, err_count1, irq1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reset_flush();
    test_write();
    test_unmapped_write();
    test_saturate();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
